// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the multiplexed hex display controller:
// scan state encoding, the all-off segment pattern and the hex glyph table.
package hex_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Segments are a..g with index 0 = a; a 0 lights the segment.
    localparam logic [0:6] SEG_OFF = 7'b1111111;

    localparam logic [0:6] SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_seg7_lut.sv
// Combinational hex nibble to active-low a..g segment decoder.
module seg7_lut
    import hex_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [0:6] seg
);

    // Straight table lookup; one instance is shared by all digits.
    always_comb begin
        seg = SEG_TABLE[nib];
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex display controller. Received bytes shift into a
// nibble history (two digits per byte); the digits are scanned one at a
// time with an all-off guard interval in front of each digit.
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank leading zero digits
// (digit 0 always shows its value).
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  hold,
    input  logic                  clear,
    output logic [0:6]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int HIST_W = NUM_DIGITS * 4;
    localparam int CNT_W  = $clog2(max2(REFRESH_DIV, GUARD_CYC) + 1);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [HIST_W-1:0]     hist;
    logic [HIST_W-1:0]     hist_shift;
    logic                  accept;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  load;

    logic [3:0]            cur_nib;
    logic                  cur_blank;
    logic [3:0]            nib;
    logic                  nib_blank;
    logic [0:6]            dec_seg;
    logic [0:6]            seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;

    assign rx_ready = !hold;
    assign accept   = rx_valid && rx_ready;

    // Newest byte enters at digits 1:0, oldest byte falls off the top.
    always_comb begin
        hist_shift      = hist << 8;
        hist_shift[7:0] = rx_data;
    end

    // History buffer; clear wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (clear) begin
            hist <= '0;
        end else if (accept) begin
            hist <= hist_shift;
        end
    end

    // Nibble of the digit about to be driven.
    always_comb begin
        cur_nib = hist[{idx, 2'b00} +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank the digit when it and every more significant digit are zero.
    always_comb begin
        logic hi_zero;
        hi_zero   = 1'b1;
        cur_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (hist[i*4 +: 4] != 4'h0) begin
                hi_zero = 1'b0;
            end
            if (IDX_W'(i) == idx) begin
                cur_blank = hi_zero;
            end
        end
    end
`else
    // Every digit shows its nibble, leading zeros included.
    always_comb begin
        cur_blank = 1'b0;
    end
`endif

    // Scan sequencing: guard blanking, then drive, then advance the digit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        load      = 1'b0;
        an_nxt    = '1;
        seg_nxt   = SEG_OFF;
        case (state)
            BLANK: begin
                if (cnt == GUARD_LAST) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                    load      = 1'b1;
                end
            end
            DRIVE: begin
                an_nxt[idx] = 1'b0;
                seg_nxt     = nib_blank ? SEG_OFF : dec_seg;
                if (cnt == DRIVE_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Scan state, cycle counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Latch the decoder input at the start of DRIVE so later buffer
    // writes cannot change the digit currently on display.
    always_ff @(posedge clk) begin
        if (load) begin
            nib       <= cur_nib;
            nib_blank <= cur_blank;
        end
    end

    seg7_lut u_seg7_lut (
        .nib (nib),
        .seg (dec_seg)
    );

    // Registered display pins, one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= '1;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with a small reference model of the
// nibble history and an expected-display queue.
module tb_hex_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       hold = 1'b0;
    logic       clear = 1'b0;
    logic       rx_ready;
    logic [0:6] seg;
    logic [3:0] an;

    always #5 clk = ~clk;

    hex_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD_CYC   (GC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .hold     (hold),
        .clear    (clear),
        .seg      (seg),
        .an       (an)
    );

    logic [0:6] dec_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [0:6] OFF = 7'b1111111;

    logic [3:0] mbuf [4];

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [0:6] seg;
    } exp_t;
    exp_t sbq[$];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oc(input int d);
        logic [3:0] v;
        v = 4'hF;
        v[d[1:0]] = 1'b0;
        return v;
    endfunction

    function automatic logic [0:6] exp_seg(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        bit z;
        z = 1'b1;
        for (int k = d; k < ND; k++) if (mbuf[k] != 4'h0) z = 1'b0;
        if (d > 0 && z) return OFF;
`endif
        return dec_tab[mbuf[d]];
    endfunction

    task automatic model_zero();
        for (int k = 0; k < ND; k++) mbuf[k] = 4'h0;
    endtask

    task automatic model_shift(input logic [7:0] b);
        mbuf[3] = mbuf[1];
        mbuf[2] = mbuf[0];
        mbuf[1] = b[7:4];
        mbuf[0] = b[3:0];
    endtask

    task automatic push_scan();
        for (int d = 0; d < ND; d++)
            sbq.push_back('{$sformatf("digit%0d", d), oc(d), exp_seg(d)});
    endtask

    task automatic wait_an(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (an === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pop each expected digit window and compare it against the next
    // complete window the DUT produces for that digit.
    task automatic drain();
        exp_t e;
        bit   ok;
        int   len;
        @(posedge clk);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            wait_an(4'hF, ok);
            if (ok) wait_an(e.an, ok);
            if (!ok) begin
                chk({e.tag, "_found"}, 32'(an), 32'(e.an));
            end else begin
                len = 0;
                do begin
                    chk({e.tag, "_seg"}, 32'(seg), 32'(e.seg));
                    len++;
                    @(negedge clk);
                end while (an === e.an && len < 10);
                chk({e.tag, "_len"}, 32'(len), 32'(RD));
            end
        end
    endtask

    // Cycle-exact scan schedule right after reset release at a negedge.
    task automatic timeline(input string tag);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < GC; c++) sbq.push_back('{$sformatf("%s_g%0d", tag, d), 4'hF, OFF});
            for (int c = 0; c < RD; c++) sbq.push_back('{$sformatf("%s_d%0d", tag, d), oc(d), exp_seg(d)});
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            chk({e.tag, "_an"}, 32'(an), 32'(e.an));
            chk({e.tag, "_seg"}, 32'(seg), 32'(e.seg));
        end
    endtask

    task automatic send(input logic [7:0] b, input logic exp_ready);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        #1;
        chk("rx_ready", 32'(rx_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        model_zero();

        // Reset state and the first scan slots with an empty buffer.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'(OFF));
        chk("rst_ready", 32'(rx_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        timeline("boot");

        // Two bytes build a four-digit history.
        send(8'h3A, 1'b1); model_shift(8'h3A);
        send(8'h7F, 1'b1); model_shift(8'h7F);
        push_scan();
        drain();

        // hold blocks acceptance.
        hold = 1'b1;
        send(8'h55, 1'b0);
        hold = 1'b0;
        push_scan();
        drain();

        // clear beats a simultaneous accept.
        clear = 1'b1;
        send(8'h99, 1'b1);
        clear = 1'b0;
        model_zero();
        push_scan();
        drain();

        // A write during digit 0 DRIVE only shows on its next DRIVE.
        wait_an(4'hF, ok);
        if (ok) wait_an(4'hE, ok);
        chk("c4_window", 32'(an), 32'hE);
        chk("c4_old_a", 32'(seg), 32'(exp_seg(0)));
        send(8'hC4, 1'b1);
        @(negedge clk);
        chk("c4_old_an", 32'(an), 32'hE);
        chk("c4_old_b", 32'(seg), 32'(exp_seg(0)));
        model_shift(8'hC4);
        push_scan();
        drain();

        // clear still acts while hold is high.
        @(negedge clk);
        hold = 1'b1; clear = 1'b1; rx_valid = 1'b1; rx_data = 8'h66;
        @(posedge clk);
        #1;
        hold = 1'b0; clear = 1'b0; rx_valid = 1'b0;
        model_zero();
        send(8'h05, 1'b1); model_shift(8'h05);
        push_scan();
        drain();

        // Reset in the middle of digit 2 DRIVE.
        wait_an(4'hF, ok);
        if (ok) wait_an(4'hB, ok);
        chk("rst2_window", 32'(an), 32'hB);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_an", 32'(an), 32'hF);
        chk("rst2_seg", 32'(seg), 32'(OFF));
        model_zero();
        @(negedge clk);
        rst_n = 1'b1;
        timeline("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
